// File: rtl/stage_sequencer.sv
// Game-flow controller: starts levels, accumulates score/money, judges each stage,
// then sequences result hold, shop upgrades, next level, game-over and win.
module stage_sequencer #(
    parameter int NUM_LEVELS     = 3,
    parameter int TARGET_BASE    = 500,
    parameter int TARGET_STEP    = 250,
    parameter int UPGRADE_COST   = 200,
    parameter int BASE_EXT_SPEED = 4,
    parameter int BASE_ROT_SPEED = 2,
    parameter int SPEED_STEP     = 1,
    parameter int MAX_SPEED      = 16,
    parameter int RESULT_HOLD    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_startKey,
    input  logic        i_buyExtend,
    input  logic        i_buyRotate,
    input  logic        i_oneSecPulse,
    input  logic        i_stageEnded,
    input  logic        i_stagePassed,
    input  logic [19:0] i_scoreIncrease,
    output logic        o_levelEnable,
    output logic        o_cycleLevel,
    output logic [7:0]  o_levelIndex,
    output logic [19:0] o_levelTarget,
    output logic [19:0] o_score,
    output logic [19:0] o_money,
    output logic [8:0]  o_extentionSpeed,
    output logic [8:0]  o_rotationSpeed,
    output logic [2:0]  o_gameState,
    output logic        o_lastPassed,
    output logic        o_purchaseDenied
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PLAYING   = 3'd1;
    localparam logic [2:0] S_RESULT    = 3'd2;
    localparam logic [2:0] S_SHOP      = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;
    localparam logic [2:0] S_WIN       = 3'd5;
    localparam int HOLD_W = $clog2(RESULT_HOLD + 1);

    logic [2:0]        r_state;
    logic [7:0]        r_levelIndex;
    logic [19:0]       r_score, r_money;
    logic [8:0]        r_ext, r_rot;
    logic              r_lastPassed, r_cycleLevel, r_denied;
    logic [HOLD_W-1:0] r_hold;

    logic [20:0] w_score_sum, w_money_sum;
    logic [19:0] w_score_add, w_money_add;
    logic [31:0] w_target_full;
    logic [9:0]  w_ext_next, w_rot_next;
    logic        w_money_ok, w_ext_ok, w_rot_ok;

    // Saturating accumulate; a zero increase leaves the value untouched anyway.
    assign w_score_sum = {1'b0, r_score} + {1'b0, i_scoreIncrease};
    assign w_money_sum = {1'b0, r_money} + {1'b0, i_scoreIncrease};
    assign w_score_add = w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
    assign w_money_add = w_money_sum[20] ? 20'hFFFFF : w_money_sum[19:0];

    assign w_target_full = 32'(TARGET_BASE) + 32'(r_levelIndex) * 32'(TARGET_STEP);
    assign o_levelTarget = (w_target_full > 32'h000F_FFFF) ? 20'hFFFFF : w_target_full[19:0];

    // One extra bit keeps speed+step from wrapping past the ceiling check.
    assign w_ext_next = {1'b0, r_ext} + 10'(SPEED_STEP);
    assign w_rot_next = {1'b0, r_rot} + 10'(SPEED_STEP);
    assign w_ext_ok   = (w_ext_next <= 10'(MAX_SPEED));
    assign w_rot_ok   = (w_rot_next <= 10'(MAX_SPEED));
    assign w_money_ok = (r_money >= 20'(UPGRADE_COST));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_levelIndex <= '0;
            r_score      <= '0;
            r_money      <= '0;
            r_ext        <= 9'(BASE_EXT_SPEED);
            r_rot        <= 9'(BASE_ROT_SPEED);
            r_lastPassed <= 1'b0;
            r_cycleLevel <= 1'b0;
            r_denied     <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_cycleLevel <= 1'b0;
            r_denied     <= 1'b0;
            case (r_state)
                S_IDLE: if (i_startKey) begin
                    r_state      <= S_PLAYING;
                    r_score      <= '0;
                    r_money      <= '0;
                    r_levelIndex <= '0;
                    r_ext        <= 9'(BASE_EXT_SPEED);
                    r_rot        <= 9'(BASE_ROT_SPEED);
                end
                S_PLAYING: begin
                    if (i_scoreIncrease != '0) begin
                        r_score <= w_score_add;
                        r_money <= w_money_add;
                    end
                    if (i_stageEnded) begin
                        r_state      <= S_RESULT;
                        r_lastPassed <= i_stagePassed || (w_score_add >= o_levelTarget);
                        r_hold       <= '0;
                    end
                end
                S_RESULT: if (i_oneSecPulse) begin
                    if (r_hold == HOLD_W'(RESULT_HOLD - 1)) begin
                        if (!r_lastPassed)
                            r_state <= S_GAME_OVER;
                        else if (r_levelIndex == 8'(NUM_LEVELS - 1))
                            r_state <= S_WIN;
                        else
                            r_state <= S_SHOP;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_SHOP: begin
                    // Start wins over buys; extend wins over rotate.
                    if (i_startKey) begin
                        r_state      <= S_PLAYING;
                        r_levelIndex <= r_levelIndex + 8'd1;
                        r_cycleLevel <= 1'b1;
                    end else if (i_buyExtend) begin
                        if (w_money_ok && w_ext_ok) begin
                            r_money <= r_money - 20'(UPGRADE_COST);
                            r_ext   <= w_ext_next[8:0];
                        end else begin
                            r_denied <= 1'b1;
                        end
                    end else if (i_buyRotate) begin
                        if (w_money_ok && w_rot_ok) begin
                            r_money <= r_money - 20'(UPGRADE_COST);
                            r_rot   <= w_rot_next[8:0];
                        end else begin
                            r_denied <= 1'b1;
                        end
                    end
                end
                S_GAME_OVER, S_WIN: if (i_startKey) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_levelEnable    = (r_state == S_PLAYING);
    assign o_cycleLevel     = r_cycleLevel;
    assign o_levelIndex     = r_levelIndex;
    assign o_score          = r_score;
    assign o_money          = r_money;
    assign o_extentionSpeed = r_ext;
    assign o_rotationSpeed  = r_rot;
    assign o_gameState      = r_state;
    assign o_lastPassed     = r_lastPassed;
    assign o_purchaseDenied = r_denied;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed game scenarios plus a randomized run
// checked cycle by cycle against a rule-level game model.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset, startKey, buyExtend, buyRotate, oneSecPulse, stageEnded, stagePassed;
    logic [19:0] scoreIncrease;
    logic        levelEnable, cycleLevel, lastPassed, purchaseDenied;
    logic [7:0]  levelIndex;
    logic [19:0] levelTarget, score, money;
    logic [8:0]  extSpeed, rotSpeed;
    logic [2:0]  gameState;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_startKey(startKey), .i_buyExtend(buyExtend),
        .i_buyRotate(buyRotate), .i_oneSecPulse(oneSecPulse), .i_stageEnded(stageEnded),
        .i_stagePassed(stagePassed), .i_scoreIncrease(scoreIncrease),
        .o_levelEnable(levelEnable), .o_cycleLevel(cycleLevel), .o_levelIndex(levelIndex),
        .o_levelTarget(levelTarget), .o_score(score), .o_money(money),
        .o_extentionSpeed(extSpeed), .o_rotationSpeed(rotSpeed), .o_gameState(gameState),
        .o_lastPassed(lastPassed), .o_purchaseDenied(purchaseDenied)
    );

    // Drive one cycle of inputs, let the edge happen, then release pulse inputs.
    task automatic cyc(input logic rst, sk, be, br, osp, se, sp, input logic [19:0] si);
        reset = rst; startKey = sk; buyExtend = be; buyRotate = br;
        oneSecPulse = osp; stageEnded = se; stagePassed = sp; scoreIncrease = si;
        @(posedge clk); #1;
        reset = 0; startKey = 0; buyExtend = 0; buyRotate = 0;
        oneSecPulse = 0; stageEnded = 0; stagePassed = 0; scoreIncrease = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 20'd0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if ({gameState, levelEnable, cycleLevel, purchaseDenied, lastPassed} !== 7'b000_0000) begin
            failures++;
            $display("FAIL reset_flags got state=%0d en=%b cl=%b den=%b lp=%b exp all 0",
                     gameState, levelEnable, cycleLevel, purchaseDenied, lastPassed);
        end
        checks++;
        if (levelIndex !== 8'd0 || score !== 20'd0 || money !== 20'd0 || levelTarget !== 20'd500) begin
            failures++;
            $display("FAIL reset_values got idx=%0d score=%0d money=%0d tgt=%0d exp 0/0/0/500",
                     levelIndex, score, money, levelTarget);
        end
        checks++;
        if (extSpeed !== 9'd4 || rotSpeed !== 9'd2) begin
            failures++;
            $display("FAIL reset_speeds got ext=%0d rot=%0d exp 4/2", extSpeed, rotSpeed);
        end
    endtask

    // Level 0: 300+250 with stagePassed=0 still passes on score, then shop.
    task automatic test_pass_to_shop();
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if (levelEnable !== 1'b1 || cycleLevel !== 1'b0 || gameState !== 3'd1) begin
            failures++;
            $display("FAIL start_level0 got en=%b cl=%b state=%0d exp 1/0/1", levelEnable, cycleLevel, gameState);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 20'd300);
        cyc(0, 0, 0, 0, 0, 0, 0, 20'd250);
        checks++;
        if (score !== 20'd550 || money !== 20'd550) begin
            failures++;
            $display("FAIL accumulate got score=%0d money=%0d exp 550/550", score, money);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 20'd0);
        checks++;
        if (gameState !== 3'd2 || levelEnable !== 1'b0 || lastPassed !== 1'b1) begin
            failures++;
            $display("FAIL stage_end got state=%0d en=%b lp=%b exp 2/0/1", gameState, levelEnable, lastPassed);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 20'd77);   // dropped outside PLAYING
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0); idle(1);
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd2 || score !== 20'd550) begin
            failures++;
            $display("FAIL hold_two_pulses got state=%0d score=%0d exp 2/550", gameState, score);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd3) begin
            failures++;
            $display("FAIL enter_shop got state=%0d exp 3", gameState);
        end
    endtask

    task automatic test_shop_purchases();
        cyc(0, 0, 1, 0, 0, 0, 0, 20'd0);
        checks++;
        if (money !== 20'd350 || extSpeed !== 9'd5 || purchaseDenied !== 1'b0) begin
            failures++;
            $display("FAIL buy_ext1 got money=%0d ext=%0d den=%b exp 350/5/0", money, extSpeed, purchaseDenied);
        end
        cyc(0, 0, 1, 0, 0, 0, 0, 20'd0);
        checks++;
        if (money !== 20'd150 || extSpeed !== 9'd6) begin
            failures++;
            $display("FAIL buy_ext2 got money=%0d ext=%0d exp 150/6", money, extSpeed);
        end
        cyc(0, 0, 0, 1, 0, 0, 0, 20'd0);
        checks++;
        if (purchaseDenied !== 1'b1 || rotSpeed !== 9'd2 || money !== 20'd150) begin
            failures++;
            $display("FAIL buy_rot_denied got den=%b rot=%0d money=%0d exp 1/2/150", purchaseDenied, rotSpeed, money);
        end
        idle(1);
        checks++;
        if (purchaseDenied !== 1'b0) begin
            failures++;
            $display("FAIL denied_pulse got den=%b exp 0", purchaseDenied);
        end
    endtask

    task automatic test_start_with_buy();
        cyc(0, 1, 1, 0, 0, 0, 0, 20'd0);
        checks++;
        if (money !== 20'd150 || extSpeed !== 9'd6 || levelIndex !== 8'd1 ||
            cycleLevel !== 1'b1 || levelEnable !== 1'b1 || levelTarget !== 20'd750) begin
            failures++;
            $display("FAIL start_buy got money=%0d ext=%0d idx=%0d cl=%b en=%b tgt=%0d exp 150/6/1/1/1/750",
                     money, extSpeed, levelIndex, cycleLevel, levelEnable, levelTarget);
        end
        idle(1);
        checks++;
        if (cycleLevel !== 1'b0) begin
            failures++;
            $display("FAIL cycle_pulse got cl=%b exp 0", cycleLevel);
        end
    endtask

    // Level 1 passed by flag, level 2 by score, with saturation and a same-cycle pulse.
    task automatic test_win_and_saturation();
        cyc(0, 0, 0, 0, 0, 1, 1, 20'd0);
        checks++;
        if (lastPassed !== 1'b1 || gameState !== 3'd2) begin
            failures++;
            $display("FAIL lvl1_pass got lp=%b state=%0d exp 1/2", lastPassed, gameState);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if (levelIndex !== 8'd2 || levelTarget !== 20'd1000 || gameState !== 3'd1) begin
            failures++;
            $display("FAIL lvl2_start got idx=%0d tgt=%0d state=%0d exp 2/1000/1", levelIndex, levelTarget, gameState);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 20'hFFFF0);
        cyc(0, 0, 0, 0, 0, 0, 0, 20'hFFFF0);
        checks++;
        if (score !== 20'hFFFFF || money !== 20'hFFFFF) begin
            failures++;
            $display("FAIL saturate got score=%h money=%h exp fffff/fffff", score, money);
        end
        cyc(0, 0, 0, 0, 1, 1, 0, 20'd0);   // pulse with stageEnded is not counted
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd2 || lastPassed !== 1'b1) begin
            failures++;
            $display("FAIL hold_ignore_pulse got state=%0d lp=%b exp 2/1", gameState, lastPassed);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd5) begin
            failures++;
            $display("FAIL win got state=%0d exp 5", gameState);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd0 || extSpeed !== 9'd6) begin
            failures++;
            $display("FAIL win_to_idle got state=%0d ext=%0d exp 0/6", gameState, extSpeed);
        end
    endtask

    task automatic test_game_over();
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if (extSpeed !== 9'd4 || score !== 20'd0 || levelIndex !== 8'd0) begin
            failures++;
            $display("FAIL restart got ext=%0d score=%0d idx=%0d exp 4/0/0", extSpeed, score, levelIndex);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 20'd300);
        cyc(0, 0, 0, 0, 0, 1, 0, 20'd0);
        checks++;
        if (lastPassed !== 1'b0 || score !== 20'd300) begin
            failures++;
            $display("FAIL fail_verdict got lp=%b score=%0d exp 0/300", lastPassed, score);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd4) begin
            failures++;
            $display("FAIL game_over got state=%0d exp 4", gameState);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        checks++;
        if (gameState !== 3'd0) begin
            failures++;
            $display("FAIL over_to_idle got state=%0d exp 0", gameState);
        end
    endtask

    task automatic test_reset_mid_level();
        cyc(0, 1, 0, 0, 0, 0, 0, 20'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 20'd400);
        checks++;
        if (score !== 20'd400) begin
            failures++;
            $display("FAIL pre_reset got score=%0d exp 400", score);
        end
        cyc(1, 1, 0, 0, 0, 1, 1, 20'd50);
        checks++;
        if (gameState !== 3'd0 || levelEnable !== 1'b0 || score !== 20'd0 || money !== 20'd0 ||
            lastPassed !== 1'b0 || levelTarget !== 20'd500 || extSpeed !== 9'd4 || rotSpeed !== 9'd2) begin
            failures++;
            $display("FAIL reset_mid got state=%0d en=%b score=%0d money=%0d lp=%b tgt=%0d ext=%0d rot=%0d",
                     gameState, levelEnable, score, money, lastPassed, levelTarget, extSpeed, rotSpeed);
        end
    endtask

    // Rule-level game model: plain integers, saturation via min().
    int m_st, m_lvl, m_hold;
    longint m_score, m_money, m_ext, m_rot;
    bit m_lp, m_cl, m_den;
    localparam longint SAT = 64'hFFFFF;

    function automatic longint sat_add(input longint a, input longint b);
        return (a + b > SAT) ? SAT : a + b;
    endfunction

    function automatic longint target_of(input int lvl);
        longint t = 500 + longint'(lvl) * 250;
        return (t > SAT) ? SAT : t;
    endfunction

    task automatic model_buy(inout longint spd);
        if (m_money >= 200 && spd + 1 <= 16) begin m_money -= 200; spd += 1; end
        else m_den = 1;
    endtask

    task automatic model_step(input bit rst, sk, be, br, osp, se, sp, input longint si);
        m_cl = 0; m_den = 0;
        if (rst) begin
            m_st = 0; m_lvl = 0; m_score = 0; m_money = 0; m_ext = 4; m_rot = 2; m_lp = 0; m_hold = 0;
        end else if (m_st == 0) begin
            if (sk) begin m_st = 1; m_score = 0; m_money = 0; m_lvl = 0; m_ext = 4; m_rot = 2; end
        end else if (m_st == 1) begin
            m_score = sat_add(m_score, si);
            m_money = sat_add(m_money, si);
            if (se) begin m_lp = sp || (m_score >= target_of(m_lvl)); m_st = 2; m_hold = 0; end
        end else if (m_st == 2) begin
            if (osp) m_hold++;
            if (m_hold == 3) m_st = !m_lp ? 4 : (m_lvl == 2 ? 5 : 3);
        end else if (m_st == 3) begin
            if (sk) begin m_st = 1; m_lvl++; m_cl = 1; end
            else if (be) model_buy(m_ext);
            else if (br) model_buy(m_rot);
        end else if (sk) begin
            m_st = 0;
        end
    endtask

    task automatic test_random();
        bit rst, sk, be, br, osp, se, sp;
        logic [19:0] si;
        logic [101:0] got, exp_v;
        int bad = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 20'd0);
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            sk  = ($urandom_range(0, 19) == 0);
            be  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            osp = ($urandom_range(0, 2) == 0);
            se  = ($urandom_range(0, 29) == 0);
            sp  = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0, 1, 2: si = 20'($urandom_range(1, 600));
                3:       si = 20'($urandom_range(20'h80000, 20'hFFFFF));
                default: si = '0;
            endcase
            cyc(rst, sk, be, br, osp, se, sp, si);
            model_step(rst, sk, be, br, osp, se, sp, longint'(si));
            got   = {gameState, levelEnable, cycleLevel, levelIndex, levelTarget, score, money,
                     extSpeed, rotSpeed, lastPassed, purchaseDenied};
            exp_v = {3'(m_st), (m_st == 1), m_cl, 8'(m_lvl), 20'(target_of(m_lvl)), 20'(m_score),
                     20'(m_money), 9'(m_ext), 9'(m_rot), m_lp, m_den};
            checks++;
            if (got !== exp_v) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL random_cycle_%0d got st=%0d en=%b cl=%b idx=%0d tgt=%0d sc=%0d mo=%0d ext=%0d rot=%0d lp=%b den=%b exp %h",
                             n, gameState, levelEnable, cycleLevel, levelIndex, levelTarget, score, money,
                             extSpeed, rotSpeed, lastPassed, purchaseDenied, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1; startKey = 0; buyExtend = 0; buyRotate = 0;
        oneSecPulse = 0; stageEnded = 0; stagePassed = 0; scoreIncrease = '0;
        #1;
        test_reset();
        test_pass_to_shop();
        test_shop_purchases();
        test_start_with_buy();
        test_win_and_saturation();
        test_game_over();
        test_reset_mid_level();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
